// File: rtl/freq_meter_hz.sv
// Gated frequency meter: counts rising edges of an asynchronous input over contiguous
// GATE_CYCLES windows. Define FREQ_METER_GLITCH_FILTER_EN to add a 3-sample majority filter.
module freq_meter_hz #(
  parameter int unsigned GATE_CYCLES = 12_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_hz,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_GATE = 2'd2;

`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam logic [1:0] SYNC_LAST = 2'd3;
`else
  localparam logic [1:0] SYNC_LAST = 2'd1;
`endif

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              sync1_q, sync2_q, prev_q;
  logic              sig_cur, rise;
  logic [1:0]        state_q, state_d;
  logic [1:0]        sync_cnt_q, sync_cnt_d;
  logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic              sat_q, sat_d;
  logic [CNT_W-1:0]  freq_q, freq_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  sum_sat;
  logic              sum_ovf;

`ifdef FREQ_METER_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;
  assign sig_cur = filt_q;
`else
  assign sig_cur = sync2_q;
`endif

  assign rise    = sig_cur & ~prev_q;
  assign sum_ovf = rise && (edge_cnt_q == CNT_MAX);
  assign sum_sat = sum_ovf ? CNT_MAX : edge_cnt_q + {{(CNT_W-1){1'b0}}, rise};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_d    = state_q;
    sync_cnt_d = sync_cnt_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sat_d      = sat_q;
    freq_d     = freq_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        gate_cnt_d = '0;
        edge_cnt_d = '0;
        sat_d      = 1'b0;
        sync_cnt_d = '0;
        if (enable) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (!enable)                     state_d    = S_IDLE;
        else if (sync_cnt_q == SYNC_LAST) state_d    = S_GATE;
        else                             sync_cnt_d = sync_cnt_q + 2'd1;
      end
      S_GATE: begin
        // The final cycle closes the window regardless of enable, so windows abut.
        if (gate_cnt_q == GATE_LAST) begin
          freq_d     = sum_sat;
          ovf_d      = sat_q | sum_ovf;
          valid_d    = 1'b1;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
          if (!enable) state_d = S_IDLE;
        end else if (!enable) begin
          state_d    = S_IDLE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          sat_d      = 1'b0;
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_W'(1);
          edge_cnt_d = sum_sat;
          sat_d      = sat_q | sum_ovf;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: rst is sampled on clk like any other input; all flops, including the synchronizer, clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
`ifdef FREQ_METER_GLITCH_FILTER_EN
      hist_q     <= '0;
      filt_q     <= 1'b0;
`endif
      state_q    <= S_IDLE;
      sync_cnt_q <= '0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_q     <= '0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q    <= sig_in;
      sync2_q    <= sync1_q;
`ifdef FREQ_METER_GLITCH_FILTER_EN
      hist_q     <= {hist_q[0], sync2_q};
      filt_q     <= (sync2_q & hist_q[0]) | (sync2_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`endif
      prev_q     <= sig_cur;
      state_q    <= state_d;
      sync_cnt_q <= sync_cnt_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sat_q      <= sat_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  assign freq_hz  = freq_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign busy     = (state_q == S_SYNC) || (state_q == S_GATE);

endmodule

// File: tb/tb_freq_meter_hz.sv
// Scoreboard bench for freq_meter_hz: a window-level reference model pushes expected results,
// a negedge monitor compares them and the held outputs every cycle.
module tb_freq_meter_hz;

  localparam int G = 1000;
  localparam int W = 4;
`ifdef FREQ_METER_GLITCH_FILTER_EN
  localparam int SYNC_LEN = 4;
  localparam int LAT      = 4;
`else
  localparam int SYNC_LEN = 2;
  localparam int LAT      = 2;
`endif
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         sig_in = 1'b0;
  logic [W-1:0] freq_hz;
  logic         valid, overflow, busy;

  freq_meter_hz #(.GATE_CYCLES(G), .CNT_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sig_in   (sig_in),
    .freq_hz  (freq_hz),
    .valid    (valid),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [W-1:0] f;
    logic         o;
  } res_t;
  res_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts edges of the sampled input over each window with an unbounded total.
  typedef enum {M_IDLE, M_SYNC, M_GATE} mode_t;
  mode_t        m_mode  = M_IDLE;
  int           m_scnt  = 0;
  int           m_pos   = 0;
  int           m_tot   = 0;
  logic [W-1:0] m_freq  = '0;
  logic         m_ov    = 1'b0;
  logic         m_valid = 1'b0;
  logic [7:0]   s_hist  = '0;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always @(posedge clk) begin
    logic e;
    res_t r;
    m_valid = 1'b0;
    if (rst) s_hist = '0;
    else     s_hist = {s_hist[6:0], sig_in};
`ifdef FREQ_METER_GLITCH_FILTER_EN
    e = maj3(s_hist[3], s_hist[4], s_hist[5]) & ~maj3(s_hist[4], s_hist[5], s_hist[6]);
`else
    e = s_hist[2] & ~s_hist[3];
`endif
    if (rst) begin
      m_mode = M_IDLE;
      m_freq = '0;
      m_ov   = 1'b0;
      m_pos  = 0;
      m_tot  = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (enable) begin m_mode = M_SYNC; m_scnt = 1; end
        M_SYNC: begin
          if (!enable) m_mode = M_IDLE;
          else if (m_scnt == SYNC_LEN) begin m_mode = M_GATE; m_pos = 0; m_tot = 0; end
          else m_scnt++;
        end
        M_GATE: begin
          m_tot += int'(e);
          if (m_pos == G - 1) begin
            m_freq  = (m_tot > MAXV) ? W'(MAXV) : W'(m_tot);
            m_ov    = (m_tot > MAXV);
            m_valid = 1'b1;
            r.f = m_freq;
            r.o = m_ov;
            exp_q.push_back(r);
            m_pos = 0;
            m_tot = 0;
            if (!enable) m_mode = M_IDLE;
          end else if (!enable) begin
            m_mode = M_IDLE;
            m_pos  = 0;
          end else m_pos++;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  // Monitor
  always @(negedge clk) begin
    res_t r;
    check("busy", busy, m_mode != M_IDLE);
    check("valid", valid, m_valid);
    if (valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got valid=1 expected no result pending at %0t", $time);
      end else begin
        r = exp_q.pop_front();
        check("freq_hz", freq_hz, r.f);
        check("overflow", overflow, r.o);
      end
    end else begin
      check("freq_hold", freq_hz, m_freq);
      check("ovf_hold", overflow, m_ov);
    end
  end

  // Stimulus
  typedef enum {P_SQUARE, P_CONST, P_GLITCH, P_RAND} pat_t;
  pat_t pat     = P_SQUARE;
  int   period  = 100;
  int   phase   = 0;
  logic const_v = 1'b0;
  logic rnd_v   = 1'b0;

  task automatic step();
    @(negedge clk);
    phase++;
    case (pat)
      P_SQUARE: sig_in = (phase % period) < (period / 2);
      P_CONST:  sig_in = const_v;
      P_GLITCH: sig_in = (phase % 50) == 0;
      default: begin
        if ($urandom_range(0, 63) == 0) rnd_v = ~rnd_v;
        sig_in = rnd_v;
      end
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (!(m_mode == M_GATE && m_pos == p)) begin
      step();
      n++;
      if (n > 3 * G) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_pos: got timeout expected gate position %0d", p);
        return;
      end
    end
  endtask

  task automatic next_pos(input int p);
    step();
    wait_pos(p);
  endtask

  initial begin
    pat = P_SQUARE;
    period = 100;
    repeat (3) step();
    rst = 1'b0;
    enable = 1'b1;
    run(SYNC_LEN + 3 * G + 5);

    wait_pos(500);
    enable = 1'b0;
    run(40);
    enable = 1'b1;
    run(SYNC_LEN + G + 3);

    wait_pos(G - LAT);
    period = 20;
    phase = 0;
    next_pos(G - LAT);
    period = 200;
    phase = 0;
    next_pos(G - LAT);
    run(5);

    wait_pos(300);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(20);

    pat = P_CONST;
    const_v = 1'b1;
    next_pos(0);
    next_pos(0);
    wait_pos(100);
    const_v = 1'b0;
    wait_pos(G - 1 - LAT);
    const_v = 1'b1;
    next_pos(5);

    pat = P_GLITCH;
    wait_pos(G - LAT);
    next_pos(G - LAT);
    next_pos(G - LAT);
    run(5);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        pat = P_SQUARE;
        period = $urandom_range(4, 300);
      end else pat = P_RAND;
      run($urandom_range(200, 2500));
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        run($urandom_range(1, 20));
        enable = 1'b1;
      end
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end

    enable = 1'b0;
    run(10);
    check("drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/freq_meter_hz.md
FREQ_METER_HZ -- requirements
Module: freq_meter_hz

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 12_000_000, gate window length in clk cycles (1 s at 12 MHz).
REQ-002 SHALL have parameter CNT_W, default 32, width of edge counter and result.
REQ-003 SHALL have port clk  input  1  system clock, 12 MHz.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port enable  input  1  run measurement while high.
REQ-006 SHALL have port sig_in  input  1  asynchronous signal under measurement.
REQ-007 SHALL have port freq_hz  output  CNT_W  rising edges counted in last completed window.
REQ-008 SHALL have port valid  output  1  one-cycle pulse when freq_hz updates.
REQ-009 SHALL have port overflow  output  1  last result saturated.
REQ-010 SHALL have port busy  output  1  high in SYNC or GATE state.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then a registered rising-edge detector (edge = cur & ~prev).
REQ-012 SHALL implement states IDLE, SYNC, GATE.
REQ-013 IDLE: gate_cnt=0, edge_cnt=0; enable=1 -> SYNC.
REQ-014 SYNC: lasts exactly 2 cycles, edges ignored; then -> GATE; enable=0 -> IDLE.
REQ-015 GATE: gate_cnt increments 0..GATE_CYCLES-1; edge_cnt increments on each edge.
REQ-016 SHALL saturate edge_cnt at all-ones and set an internal sticky saturation flag for the window.
REQ-017 On cycle gate_cnt==GATE_CYCLES-1: freq_hz <= edge_cnt + edge (saturating); overflow <= window saturation flag; valid=1 next cycle coincident with new freq_hz.
REQ-018 Same cycle: gate_cnt, edge_cnt, saturation flag cleared; stay GATE if enable=1, else -> IDLE; windows contiguous, no cycle lost.
REQ-019 Edge on final window cycle SHALL count in the ending window; edge on the first cycle SHALL count in the new window.
REQ-020 enable=0 during GATE before final cycle SHALL abort -> IDLE, discard counts, no valid, freq_hz/overflow unchanged.
REQ-021 freq_hz and overflow SHALL hold between updates; valid never high two consecutive cycles.
REQ-022 busy SHALL be combinational decode of state (SYNC or GATE).

Reset
REQ-023 rst SHALL force state IDLE, freq_hz=0, valid=0, overflow=0, busy=0, all counters and synchronizer/filter flops 0, next clk edge.
REQ-024 rst mid-window SHALL discard the window with no valid; rst SHALL dominate enable.

Configuration
REQ-025 Macro FREQ_METER_GLITCH_FILTER_EN defined: 3-sample majority filter between synchronizer and edge detector, +2 cycles latency, pulses under 2 clk cycles rejected; SYNC lasts 4 cycles.
REQ-026 Macro undefined: synchronizer output feeds edge detector directly; SYNC lasts 2 cycles.

Verification (GATE_CYCLES=1000 for sim)
REQ-027 sig_in square, period 100 clk, enable held -> valid every 1000 cycles, freq_hz=10, overflow=0.
REQ-028 enable dropped at gate_cnt=500 -> busy=0 next cycle, no valid, freq_hz holds; re-enable -> first valid after SYNC+1000 cycles.
REQ-029 CNT_W=4, period 20 (50 edges) -> freq_hz=15, overflow=1; next window period 200 -> freq_hz=5, overflow=0.
REQ-030 rst at gate_cnt=300 -> next cycle freq_hz=0, valid=0, busy=0, overflow=0.
REQ-031 sig_in constant 1 -> freq_hz=0 each window; edge placed at gate_cnt=999 counted in that window.
REQ-032 1-cycle glitch every 50 clk -> freq_hz=20 without FREQ_METER_GLITCH_FILTER_EN, 0 with it.
